// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MAX_DATA_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Data-field width selected by the 2-bit configuration code (0..3 => 5..8).
    function automatic logic [3:0] nbits(input logic [1:0] data_bits);
        return 4'd5 + {2'b00, data_bits};
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_bit_sync (
    input  logic pclk,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw line through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, held at line-idle level during reset.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/slave_rx_deserializer.sv
// UART receive stage: oversampled start detect, LSB-first shift of 5..8 data
// bits, optional parity, one or two stop bits, valid/ready byte output.
//
// state  | meaning
// IDLE   | waiting for a low line on a baud tick
// START  | confirming the start bit at mid-bit
// DATA   | sampling data bits every OVERSAMPLE ticks
// PARITY | sampling the parity bit
// STOP   | sampling stop bit(s), then frame complete
module slave_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MAX_DATA   = MAX_DATA_DEF
) (
    input  logic                pclk,
    input  logic                areset,
    input  logic                baud_tick,
    input  logic                rx,
    input  logic [1:0]          cfg_data_bits,
    input  logic                cfg_parity_en,
    input  logic                cfg_parity_odd,
    input  logic                cfg_stop2,
    output logic [MAX_DATA-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err,
    output logic                busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    logic rx_sync;

    rx_state_e           state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic                stop_second_q, stop_second_d;
    logic [MAX_DATA-1:0] shift_q, shift_d;
    logic                perr_acc_q, perr_acc_d;
    logic                ferr_acc_q, ferr_acc_d;
    logic                done_q, done_d;

    logic [3:0]          nbits_q, nbits_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                stop2_q, stop2_d;

    logic [MAX_DATA-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;

    uart_bit_sync u_sync (
        .pclk   (pclk),
        .areset (areset),
        .d      (rx),
        .q      (rx_sync)
    );

    // State register.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, frame accumulators, latched config and output register.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            tick_q        <= '0;
            bit_q         <= '0;
            stop_second_q <= 1'b0;
            shift_q       <= '0;
            perr_acc_q    <= 1'b0;
            ferr_acc_q    <= 1'b0;
            done_q        <= 1'b0;
            nbits_q       <= 4'd8;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            stop2_q       <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            stop_second_q <= stop_second_d;
            shift_q       <= shift_d;
            perr_acc_q    <= perr_acc_d;
            ferr_acc_q    <= ferr_acc_d;
            done_q        <= done_d;
            nbits_q       <= nbits_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            stop2_q       <= stop2_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state and bit-level datapath; everything advances only on baud ticks.
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        stop_second_d = stop_second_q;
        shift_d       = shift_q;
        perr_acc_d    = perr_acc_q;
        ferr_acc_d    = ferr_acc_q;
        done_d        = 1'b0;
        nbits_d       = nbits_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        stop2_d       = stop2_q;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d       = START;
                        tick_d        = '0;
                        bit_d         = '0;
                        stop_second_d = 1'b0;
                        shift_d       = '0;
                        perr_acc_d    = 1'b0;
                        ferr_acc_d    = 1'b0;
                        nbits_d       = nbits(cfg_data_bits);
                        par_en_d      = cfg_parity_en;
                        par_odd_d     = cfg_parity_odd;
                        stop2_d       = cfg_stop2;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rx_sync) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        for (int i = 0; i < MAX_DATA; i++) begin
                            if (bit_q == 4'(i)) begin
                                shift_d[i] = rx_sync;
                            end
                        end
                        if (bit_q == nbits_q - 4'd1) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_q == TICK_END) begin
                        tick_d     = '0;
                        perr_acc_d = ((rx_sync ^ (^shift_q)) != par_odd_q);
                        state_d    = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (!rx_sync) begin
                            ferr_acc_d = 1'b1;
                        end
                        if (stop2_q && !stop_second_q) begin
                            stop_second_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register: load a finished frame when empty or being drained, else flag overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_acc_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // FSM-derived outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_slave_rx_deserializer.sv
// Bench for slave_rx_deserializer: directed frames with a scoreboard queue.
module tb_slave_rx_deserializer;

    localparam int OS      = 16;
    localparam int TPB     = 4;
    localparam int BIT_CYC = OS * TPB;

    logic       pclk = 1'b0;
    logic       areset = 1'b0;
    logic       baud_tick;
    logic       rx = 1'b1;
    logic [1:0] cfg_data_bits = 2'd3;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    slave_rx_deserializer #(.OVERSAMPLE(OS), .MAX_DATA(8)) dut (
        .pclk           (pclk),
        .areset         (areset),
        .baud_tick      (baud_tick),
        .rx             (rx),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err),
        .busy           (busy)
    );

    always #5 pclk = ~pclk;

    int tick_div = 0;
    always @(posedge pclk) begin
        tick_div  <= (tick_div == TPB - 1) ? 0 : tick_div + 1;
        baud_tick <= (tick_div == TPB - 1);
    end

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_cnt   = 0;
    int   ov_cnt   = 0;
    bit   busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake pops one expected frame.
    always @(negedge pclk) begin
        if (areset) begin
            if (busy) busy_seen = 1'b1;
            if (overrun_err) ov_cnt++;
            if (rx_valid && rx_ready) begin
                exp_t e;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got data 0x%0h, no frame expected", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.d));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int ticks);
        rx = b;
        repeat (ticks * TPB) @(posedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                              input bit st2, input bit pflip, input int stop_low_ticks);
        logic p;
        p = podd;
        drive_bit(1'b0, OS);
        for (int i = 0; i < nb; i++) begin
            drive_bit(d[i], OS);
            p = p ^ d[i];
        end
        if (pen) drive_bit(p ^ pflip, OS);
        if (stop_low_ticks > 0) begin
            drive_bit(1'b0, stop_low_ticks);
            drive_bit(1'b1, OS);
        end else begin
            drive_bit(1'b1, OS);
        end
        if (st2) drive_bit(1'b1, OS);
        drive_bit(1'b1, 2 * OS);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge pclk);
            n++;
        end
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_rx_data"}, 32'(rx_data), 32'd0);
        check({name, "_parity_err"}, 32'(parity_err), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_overrun_err"}, 32'(overrun_err), 32'd0);
    endtask

    initial begin
        int h0;
        int o0;

        repeat (5) @(posedge pclk);
        #1 check_idle_outputs("reset");
        areset = 1'b1;
        repeat (BIT_CYC) @(posedge pclk);

        // 8N1 0xA5
        h0 = hs_cnt;
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("8n1");
        repeat (10) @(posedge pclk);
        check("8n1_handshakes", 32'(hs_cnt - h0), 32'd1);

        // 7E1 0x35, good then flipped parity
        cfg_data_bits = 2'd2;
        cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b0;
        expect_frame(8'h35, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        expect_frame(8'h35, 1'b1, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        wait_drain("7e1");

        // 8N1 0x3C with low stop bit, then a clean 0x01
        cfg_data_bits = 2'd3;
        cfg_parity_en = 1'b0;
        expect_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        expect_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("ferr");

        // 4-tick low glitch on an idle line
        repeat (BIT_CYC) @(posedge pclk);
        h0 = hs_cnt;
        busy_seen = 1'b0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * OS);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_after", 32'(busy), 32'd0);
        check("glitch_no_frame", 32'(hs_cnt - h0), 32'd0);
        check("glitch_rx_valid", 32'(rx_valid), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        @(posedge pclk);
        #1 rx_ready = 1'b0;
        h0 = hs_cnt;
        o0 = ov_cnt;
        expect_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (20) @(posedge pclk);
        #1;
        check("ovr_rx_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_rx_data_held", 32'(rx_data), 32'h11);
        check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        rx_ready = 1'b1;
        wait_drain("ovr");
        repeat (BIT_CYC) @(posedge pclk);
        check("ovr_handshakes", 32'(hs_cnt - h0), 32'd1);

        // Reset mid-DATA of 0x5A, then 0xC3
        h0 = hs_cnt;
        drive_bit(1'b0, OS);
        drive_bit(1'b0, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b0, OS);
        drive_bit(1'b1, OS / 2);
        areset = 1'b0;
        #1 check_idle_outputs("midreset");
        rx = 1'b1;
        repeat (2 * BIT_CYC) @(posedge pclk);
        #1 check("midreset_busy_held", 32'(busy), 32'd0);
        areset = 1'b1;
        repeat (2 * BIT_CYC) @(posedge pclk);
        check("midreset_no_partial", 32'(hs_cnt - h0), 32'd0);
        expect_frame(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("post_reset");

        repeat (10) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
